cache_access_arbiter: RTL and testbench

Shares the single cache-controller request port between the CPU request stream and ACE snoop requests arriving from the interconnect. Captures one winning request at a time, issues it to the cache controller, waits for `cache_complete`, and returns a done pulse to the originator. Snoops have priority over CPU requests. An optional burst guard bounds how long the CPU can be starved. A watchdog aborts a transaction that never completes.

---
 rtl/cache_arb_pkg.sv | 36 +++
 rtl/cache_arb_watchdog.sv | 52 +++++
 rtl/cache_access_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_cache_access_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// -----------------------------------------------------------------------------
// cache_arb_pkg
// Shared types and encodings for the cache access arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   arb_src_t   : originator of the captured request (CPU or snoop)
//   REQ_*       : cache_request encodings driven to the cache controller
//   CPU_OP_*    : cpu_request codes that are not issued to the controller
//   SNP_*       : ACE snoop type encodings
// -----------------------------------------------------------------------------
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } arb_state_t;

  typedef enum logic {
    SRC_CPU   = 1'b0,
    SRC_SNOOP = 1'b1
  } arb_src_t;

  localparam logic [1:0] REQ_READ  = 2'b00;
  localparam logic [1:0] REQ_WRITE = 2'b01;
  localparam logic [1:0] REQ_SNOOP = 2'b10;
  localparam logic [1:0] REQ_NONE  = 2'b11;

  localparam logic [1:0] CPU_OP_RESERVED = 2'b10;
  localparam logic [1:0] CPU_OP_NONE     = 2'b11;

  localparam logic [1:0] SNP_READ_SHARED   = 2'b00;
  localparam logic [1:0] SNP_READ_UNIQUE   = 2'b01;
  localparam logic [1:0] SNP_CLEAN_INVALID = 2'b10;
  localparam logic [1:0] SNP_MAKE_INVALID  = 2'b11;

endpackage

// File: rtl/cache_arb_watchdog.sv
// -----------------------------------------------------------------------------
// cache_arb_watchdog
// Cycle counter that bounds how long the arbiter waits for cache_complete.
// Ports:
//   clk     in  : clock, rising edge
//   reset   in  : asynchronous active-low reset
//   clear   in  : restart the count (asserted on the issue strobe)
//   enable  in  : count this cycle (asserted while waiting for completion)
//   expired out : the count reaches TIMEOUT_CYCLES-1 on this clock edge
// -----------------------------------------------------------------------------
module cache_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter holds TIMEOUT_CYCLES-2 in the cycle in which it steps to
  // TIMEOUT_CYCLES-1, so the abort lands TIMEOUT_CYCLES cycles after issue.
  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Counter next-state: clear wins over counting.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == EXPIRE_AT);

endmodule

// File: rtl/cache_access_arbiter.sv
// -----------------------------------------------------------------------------
// cache_access_arbiter
// Shares the cache-controller request port between CPU requests and ACE
// snoops. One request is captured at a time, issued, and tracked until
// cache_complete (or watchdog abort), then a done pulse goes to the source.
// Snoops have priority over the CPU.
//
// Optional feature macro: CACHE_ARB_STARVE_GUARD_EN
//   defined   : after MAX_SNOOP_BURST consecutive snoop grants with a CPU
//               request waiting, the CPU wins the next arbitration
//   undefined : strict snoop priority, no burst counter
//
// Ports:
//   clk, reset (async active-low)
//   cpu_valid/cpu_request/cpu_addr -> cpu_ready (comb), cpu_done (pulse)
//   snoop_valid/snoop_type/snoop_addr -> snoop_ready (comb), snoop_done
//   cache_ready, cache_complete -> cache_start (issue strobe),
//   cache_request, cache_snoop_type, cache_addr (held fields)
//   timeout_err : sticky watchdog abort flag
// -----------------------------------------------------------------------------
module cache_access_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_SNOOP_BURST = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_valid,
  input  logic [1:0]            cpu_request,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  input  logic                  snoop_valid,
  input  logic [1:0]            snoop_type,
  input  logic [ADDR_WIDTH-1:0] snoop_addr,
  output logic                  snoop_ready,
  output logic                  snoop_done,
  input  logic                  cache_ready,
  input  logic                  cache_complete,
  output logic                  cache_start,
  output logic [1:0]            cache_request,
  output logic [1:0]            cache_snoop_type,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  timeout_err
);

  arb_state_t            state_q, state_d;
  arb_src_t              src_q, src_d;
  logic [1:0]            req_q, req_d;
  logic [1:0]            stype_q, stype_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  cpu_done_q, cpu_done_d;
  logic                  snoop_done_q, snoop_done_d;
  logic                  timeout_q, timeout_d;

  logic cpu_req_valid_s;
  logic guard_trip_s;
  logic cpu_ready_s;
  logic snoop_ready_s;
  logic cache_start_s;
  logic wd_enable_s;
  logic wd_expired_s;

  assign cpu_req_valid_s = cpu_valid && (cpu_request != CPU_OP_NONE);
  assign wd_enable_s     = (state_q == ST_WAIT);

`ifdef CACHE_ARB_STARVE_GUARD_EN
  localparam logic [3:0] BURST_MAX = 4'(MAX_SNOOP_BURST);

  logic [3:0] burst_q, burst_d;

  assign guard_trip_s = cpu_req_valid_s && (burst_q == BURST_MAX);

  // Burst counter next-state: counts snoop grants that overtook a waiting CPU.
  always_comb begin
    burst_d = burst_q;
    if (state_q == ST_IDLE) begin
      if (cpu_ready_s || !cpu_req_valid_s) begin
        burst_d = 4'd0;
      end else if (snoop_ready_s && (burst_q != BURST_MAX)) begin
        burst_d = burst_q + 4'd1;
      end else begin
        burst_d = burst_q;
      end
    end else begin
      burst_d = burst_q;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_q <= 4'd0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  logic [3:0] unused_burst_cfg_s;

  assign guard_trip_s       = 1'b0;
  assign unused_burst_cfg_s = 4'(MAX_SNOOP_BURST);
`endif

  cache_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (cache_start_s),
    .enable (wd_enable_s),
    .expired(wd_expired_s)
  );

  // FSM next-state, arbitration, capture and completion handling.
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    req_d         = req_q;
    stype_d       = stype_q;
    addr_d        = addr_q;
    cpu_done_d    = 1'b0;
    snoop_done_d  = 1'b0;
    timeout_d     = timeout_q;
    cpu_ready_s   = 1'b0;
    snoop_ready_s = 1'b0;
    cache_start_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (snoop_valid && !guard_trip_s) begin
          snoop_ready_s = 1'b1;
          src_d         = SRC_SNOOP;
          req_d         = REQ_SNOOP;
          stype_d       = snoop_type;
          addr_d        = snoop_addr;
          state_d       = ST_ISSUE;
        end else if (cpu_req_valid_s) begin
          cpu_ready_s = 1'b1;
          // A reserved opcode is accepted and discarded without issue.
          if (cpu_request == CPU_OP_RESERVED) begin
            state_d = ST_IDLE;
          end else begin
            src_d   = SRC_CPU;
            req_d   = cpu_request;
            stype_d = 2'b00;
            addr_d  = cpu_addr;
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (cache_ready) begin
          cache_start_s = 1'b1;
          state_d       = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_WAIT: begin
        if (cache_complete || wd_expired_s) begin
          cpu_done_d   = (src_q == SRC_CPU);
          snoop_done_d = (src_q == SRC_SNOOP);
          // Completion in the expiry cycle counts as a normal finish.
          if (!cache_complete) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
          req_d   = REQ_NONE;
          stype_d = 2'b00;
          addr_d  = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      default: begin
        req_d   = REQ_NONE;
        stype_d = 2'b00;
        addr_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, holding and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      src_q        <= SRC_CPU;
      req_q        <= REQ_NONE;
      stype_q      <= 2'b00;
      addr_q       <= '0;
      cpu_done_q   <= 1'b0;
      snoop_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      req_q        <= req_d;
      stype_q      <= stype_d;
      addr_q       <= addr_d;
      cpu_done_q   <= cpu_done_d;
      snoop_done_q <= snoop_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign cpu_ready        = cpu_ready_s;
  assign snoop_ready      = snoop_ready_s;
  assign cache_start      = cache_start_s;
  assign cpu_done         = cpu_done_q;
  assign snoop_done       = snoop_done_q;
  assign cache_request    = req_q;
  assign cache_snoop_type = stype_q;
  assign cache_addr       = addr_q;
  assign timeout_err      = timeout_q;

endmodule

// File: tb/tb_cache_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_access_arbiter
// Directed bench for cache_access_arbiter (ADDR_WIDTH=32, MAX_SNOOP_BURST=2,
// TIMEOUT_CYCLES=8). Inputs change 2 time units after the rising edge and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cache_access_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_valid;
  logic [1:0]  cpu_request;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_done;
  logic        snoop_valid;
  logic [1:0]  snoop_type;
  logic [31:0] snoop_addr;
  logic        snoop_ready;
  logic        snoop_done;
  logic        cache_ready;
  logic        cache_complete;
  logic        cache_start;
  logic [1:0]  cache_request;
  logic [1:0]  cache_snoop_type;
  logic [31:0] cache_addr;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  cache_access_arbiter #(
    .ADDR_WIDTH     (32),
    .MAX_SNOOP_BURST(2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_valid       (cpu_valid),
    .cpu_request     (cpu_request),
    .cpu_addr        (cpu_addr),
    .cpu_ready       (cpu_ready),
    .cpu_done        (cpu_done),
    .snoop_valid     (snoop_valid),
    .snoop_type      (snoop_type),
    .snoop_addr      (snoop_addr),
    .snoop_ready     (snoop_ready),
    .snoop_done      (snoop_done),
    .cache_ready     (cache_ready),
    .cache_complete  (cache_complete),
    .cache_start     (cache_start),
    .cache_request   (cache_request),
    .cache_snoop_type(cache_snoop_type),
    .cache_addr      (cache_addr),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Waits (bounded) for a ready, checking the current cycle first.
  task automatic wait_grant(input string tag, input bit want_cpu, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((want_cpu ? cpu_ready : snoop_ready) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      next_cycle();
      sample();
    end
    chk_eq(tag, 32'(seen), 32'd1);
  endtask

  int grants[4];
  int n_g;

  initial begin
    reset          = 1'b0;
    cpu_valid      = 1'b0;
    cpu_request    = 2'b11;
    cpu_addr       = 32'h0;
    snoop_valid    = 1'b0;
    snoop_type     = 2'b00;
    snoop_addr     = 32'h0;
    cache_ready    = 1'b0;
    cache_complete = 1'b0;

    // Reset values
    sample();
    chk_eq("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk_eq("rst_snoop_ready", 32'(snoop_ready), 32'd0);
    chk_eq("rst_cpu_done", 32'(cpu_done), 32'd0);
    chk_eq("rst_snoop_done", 32'(snoop_done), 32'd0);
    chk_eq("rst_start", 32'(cache_start), 32'd0);
    chk_eq("rst_req", 32'(cache_request), 32'd3);
    chk_eq("rst_addr", cache_addr, 32'h0);
    chk_eq("rst_stype", 32'(cache_snoop_type), 32'd0);
    chk_eq("rst_terr", 32'(timeout_err), 32'd0);
    next_cycle(); reset = 1'b1;
    next_cycle();

    // cpu_request 11 is not a request
    cpu_valid = 1'b1; cpu_request = 2'b11; sample();
    chk_eq("none_nordy", 32'(cpu_ready), 32'd0);

    // CPU read alone
    next_cycle(); cpu_request = 2'b00; cpu_addr = 32'h40; cache_ready = 1'b1; sample();
    chk_eq("t1_rdy", 32'(cpu_ready), 32'd1);
    chk_eq("t1_srdy", 32'(snoop_ready), 32'd0);
    next_cycle(); cpu_valid = 1'b0; cpu_request = 2'b11; sample();
    chk_eq("t1_start", 32'(cache_start), 32'd1);
    chk_eq("t1_req", 32'(cache_request), 32'd0);
    chk_eq("t1_addr", cache_addr, 32'h40);
    next_cycle(); sample();
    chk_eq("t1_start_once", 32'(cache_start), 32'd0);
    chk_eq("t1_req_hold", 32'(cache_request), 32'd0);
    next_cycle(); sample();
    next_cycle(); cache_complete = 1'b1; sample();
    chk_eq("t1_no_early_done", 32'(cpu_done), 32'd0);
    next_cycle(); cache_complete = 1'b0; sample();
    chk_eq("t1_done", 32'(cpu_done), 32'd1);
    chk_eq("t1_idle_req", 32'(cache_request), 32'd3);
    chk_eq("t1_idle_addr", cache_addr, 32'h0);
    next_cycle(); sample();
    chk_eq("t1_done_pulse", 32'(cpu_done), 32'd0);

    // Reserved opcode: accepted, dropped
    next_cycle(); cpu_valid = 1'b1; cpu_request = 2'b10; cpu_addr = 32'h44; sample();
    chk_eq("rsv_rdy", 32'(cpu_ready), 32'd1);
    next_cycle(); cpu_valid = 1'b0; cpu_request = 2'b11; sample();
    chk_eq("rsv_nostart", 32'(cache_start), 32'd0);
    chk_eq("rsv_req", 32'(cache_request), 32'd3);
    next_cycle(); sample();
    chk_eq("rsv_nodone", 32'(cpu_done), 32'd0);

    // Simultaneous CPU write and snoop ReadUnique
    next_cycle();
    cpu_valid = 1'b1; cpu_request = 2'b01; cpu_addr = 32'h80;
    snoop_valid = 1'b1; snoop_type = 2'b01; snoop_addr = 32'hC0;
    sample();
    chk_eq("t2_snp_rdy", 32'(snoop_ready), 32'd1);
    chk_eq("t2_cpu_wait", 32'(cpu_ready), 32'd0);
    next_cycle(); snoop_valid = 1'b0; sample();
    chk_eq("t2_snp_start", 32'(cache_start), 32'd1);
    chk_eq("t2_snp_req", 32'(cache_request), 32'd2);
    chk_eq("t2_snp_type", 32'(cache_snoop_type), 32'd1);
    chk_eq("t2_snp_addr", cache_addr, 32'hC0);
    chk_eq("t2_cpu_busy", 32'(cpu_ready), 32'd0);
    next_cycle(); cache_complete = 1'b1; sample();
    next_cycle(); cache_complete = 1'b0; sample();
    chk_eq("t2_snp_done", 32'(snoop_done), 32'd1);
    chk_eq("t2_no_cpu_done", 32'(cpu_done), 32'd0);
    wait_grant("t2_cpu_grant", 1'b1, 4);
    next_cycle(); cpu_valid = 1'b0; cpu_request = 2'b11; sample();
    chk_eq("t2_cpu_start", 32'(cache_start), 32'd1);
    chk_eq("t2_cpu_req", 32'(cache_request), 32'd1);
    chk_eq("t2_cpu_addr", cache_addr, 32'h80);
    chk_eq("t2_cpu_type", 32'(cache_snoop_type), 32'd0);
    next_cycle(); cache_complete = 1'b1; sample();
    next_cycle(); cache_complete = 1'b0; sample();
    chk_eq("t2_cpu_done", 32'(cpu_done), 32'd1);
    chk_eq("t2_no_snp_done", 32'(snoop_done), 32'd0);

    // Continuous snoops with the CPU waiting
    next_cycle();
    cache_complete = 1'b1;
    snoop_valid = 1'b1; snoop_type = 2'b00; snoop_addr = 32'h100;
    cpu_valid = 1'b1; cpu_request = 2'b00; cpu_addr = 32'h200;
    sample();
    n_g = 0;
    for (int i = 0; i < 30 && n_g < 4; i++) begin
      chk_eq("t3_excl", 32'(cpu_ready & snoop_ready), 32'd0);
      if (snoop_ready === 1'b1) begin
        grants[n_g] = 0; n_g++;
      end else if (cpu_ready === 1'b1) begin
        grants[n_g] = 1; n_g++;
      end
      next_cycle(); sample();
    end
    chk_eq("t3_grant_count", 32'(n_g), 32'd4);
    chk_eq("t3_g0", 32'(grants[0]), 32'd0);
    chk_eq("t3_g1", 32'(grants[1]), 32'd0);
`ifdef CACHE_ARB_STARVE_GUARD_EN
    chk_eq("t3_g2", 32'(grants[2]), 32'd1);
`else
    chk_eq("t3_g2", 32'(grants[2]), 32'd0);
`endif
    chk_eq("t3_g3", 32'(grants[3]), 32'd0);
    next_cycle(); snoop_valid = 1'b0; cpu_valid = 1'b0; cpu_request = 2'b11;
    repeat (4) next_cycle();
    cache_complete = 1'b0;
    next_cycle(); sample();
    chk_eq("t3_drained", 32'(cache_request), 32'd3);

    // Issue stall
    next_cycle(); cache_ready = 1'b0; cpu_valid = 1'b1; cpu_request = 2'b01; cpu_addr = 32'h300; sample();
    chk_eq("t4_rdy", 32'(cpu_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      if (k == 0) begin
        cpu_valid = 1'b0; cpu_request = 2'b11;
      end
      sample();
      chk_eq("t4_stall_start", 32'(cache_start), 32'd0);
      chk_eq("t4_stall_req", 32'(cache_request), 32'd1);
      chk_eq("t4_stall_addr", cache_addr, 32'h300);
    end
    next_cycle(); cache_ready = 1'b1; sample();
    chk_eq("t4_start", 32'(cache_start), 32'd1);
    chk_eq("t4_req", 32'(cache_request), 32'd1);
    chk_eq("t4_addr", cache_addr, 32'h300);
    next_cycle(); sample();
    chk_eq("t4_start_once", 32'(cache_start), 32'd0);
    next_cycle(); cache_complete = 1'b1; sample();
    next_cycle(); cache_complete = 1'b0; sample();
    chk_eq("t4_done", 32'(cpu_done), 32'd1);

    // Timeout on a CleanInvalid snoop
    next_cycle(); snoop_valid = 1'b1; snoop_type = 2'b10; snoop_addr = 32'h500; sample();
    chk_eq("t5_rdy", 32'(snoop_ready), 32'd1);
    next_cycle(); snoop_valid = 1'b0; sample();
    chk_eq("t5_start", 32'(cache_start), 32'd1);
    chk_eq("t5_type", 32'(cache_snoop_type), 32'd2);
    for (int k = 1; k <= 7; k++) begin
      next_cycle(); sample();
      chk_eq("t5_early_done", 32'(snoop_done), 32'd0);
      chk_eq("t5_early_terr", 32'(timeout_err), 32'd0);
    end
    next_cycle(); sample();
    chk_eq("t5_done", 32'(snoop_done), 32'd1);
    chk_eq("t5_terr", 32'(timeout_err), 32'd1);
    chk_eq("t5_req_none", 32'(cache_request), 32'd3);
    next_cycle(); sample();
    chk_eq("t5_terr_sticky", 32'(timeout_err), 32'd1);
    chk_eq("t5_done_pulse", 32'(snoop_done), 32'd0);
    next_cycle(); reset = 1'b0; sample();
    chk_eq("t5_terr_rst", 32'(timeout_err), 32'd0);
    next_cycle(); reset = 1'b1;

    // Completion coinciding with expiry
    next_cycle(); cpu_valid = 1'b1; cpu_request = 2'b00; cpu_addr = 32'h600; sample();
    chk_eq("t5b_rdy", 32'(cpu_ready), 32'd1);
    next_cycle(); cpu_valid = 1'b0; cpu_request = 2'b11; sample();
    chk_eq("t5b_start", 32'(cache_start), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      next_cycle(); sample();
    end
    next_cycle(); cache_complete = 1'b1; sample();
    chk_eq("t5b_no_early_done", 32'(cpu_done), 32'd0);
    next_cycle(); cache_complete = 1'b0; sample();
    chk_eq("t5b_done", 32'(cpu_done), 32'd1);
    chk_eq("t5b_no_terr", 32'(timeout_err), 32'd0);

    // Reset during WAIT
    next_cycle(); cpu_valid = 1'b1; cpu_request = 2'b00; cpu_addr = 32'h700; sample();
    next_cycle(); cpu_valid = 1'b0; cpu_request = 2'b11; sample();
    chk_eq("t6_start", 32'(cache_start), 32'd1);
    next_cycle(); sample();
    chk_eq("t6_wait_addr", cache_addr, 32'h700);
    next_cycle(); reset = 1'b0; cache_complete = 1'b1; #1;
    chk_eq("t6_rst_req", 32'(cache_request), 32'd3);
    chk_eq("t6_rst_addr", cache_addr, 32'h0);
    sample();
    chk_eq("t6_rst_nodone", 32'(cpu_done), 32'd0);
    next_cycle(); reset = 1'b1; cache_complete = 1'b0; sample();
    chk_eq("t6_post_nodone", 32'(cpu_done), 32'd0);
    chk_eq("t6_post_req", 32'(cache_request), 32'd3);
    next_cycle(); cpu_valid = 1'b1; cpu_request = 2'b01; cpu_addr = 32'h740; sample();
    chk_eq("t6_fresh_rdy", 32'(cpu_ready), 32'd1);
    next_cycle(); cpu_valid = 1'b0; cpu_request = 2'b11; sample();
    chk_eq("t6_fresh_start", 32'(cache_start), 32'd1);
    chk_eq("t6_fresh_req", 32'(cache_request), 32'd1);
    chk_eq("t6_fresh_addr", cache_addr, 32'h740);
    next_cycle(); cache_complete = 1'b1; sample();
    next_cycle(); cache_complete = 1'b0; sample();
    chk_eq("t6_fresh_done", 32'(cpu_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit reached");
    $fatal(1, "simulation time limit");
  end

endmodule
